// File: rtl/can_af_pkg.sv
// Shared types and helpers for the CAN acceptance filter.
// Statistics counters are built only when CAN_AF_STATS_EN is defined.
package can_af_pkg;

    localparam int CAN_AF_ID_W  = 32;
    localparam int CAN_AF_MSG_W = 128;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_EVAL      = 2'd1,
        S_WAIT_FIFO = 2'd2,
        S_WRITE     = 2'd3
    } af_state_t;

    function automatic logic af_match(
        input logic [CAN_AF_ID_W-1:0] id,
        input logic [CAN_AF_ID_W-1:0] mask,
        input logic [CAN_AF_ID_W-1:0] ref_id
    );
        return (id & mask) == (ref_id & mask);
    endfunction

endpackage

// File: rtl/can_af_match_unit.sv
// Per-filter mask/ID compare with lowest-index priority encode.
// An all-zero enable vector means pass-all with index 0.
module can_af_match_unit
    import can_af_pkg::*;
#(
    parameter int NUM_FILTERS = 4,
    parameter int ID_W        = CAN_AF_ID_W,
    parameter int IDX_W       = 2
) (
    input  logic [ID_W-1:0]             i_id,
    input  logic [NUM_FILTERS*ID_W-1:0] i_afmr,
    input  logic [NUM_FILTERS*ID_W-1:0] i_afir,
    input  logic [NUM_FILTERS-1:0]      i_uaf,
    output logic                        o_accept,
    output logic [IDX_W-1:0]            o_hit_idx
);

    logic [NUM_FILTERS-1:0] w_hit;

    for (genvar k = 0; k < NUM_FILTERS; k++) begin : g_flt
        logic [ID_W-1:0] w_m;
        logic [ID_W-1:0] w_r;
        assign w_m = i_afmr[k*ID_W +: ID_W];
        assign w_r = i_afir[k*ID_W +: ID_W];
        if (ID_W == CAN_AF_ID_W) begin : g_fn
            assign w_hit[k] = i_uaf[k] && af_match(i_id, w_m, w_r);
        end else begin : g_inl
            assign w_hit[k] = i_uaf[k] &&
                              ((i_id & w_m) == (w_r & w_m));
        end
    end

    always_comb begin
        o_accept  = (|w_hit) || (i_uaf == '0);
        o_hit_idx = '0;
        // Walk downward so the lowest matching filter wins.
        for (int k = NUM_FILTERS - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                o_hit_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/can_acceptance_filter_n.sv
// CAN RX acceptance filter: capture, evaluate, FIFO write with wait.
// Define CAN_AF_STATS_EN to build the reject/overrun counters.
module can_acceptance_filter_n
    import can_af_pkg::*;
#(
    parameter int NUM_FILTERS = 4,
    parameter int MSG_W       = CAN_AF_MSG_W,
    parameter int ID_W        = CAN_AF_ID_W,
    parameter int CNT_W       = 16,
    localparam int IDX_W      = (NUM_FILTERS > 1) ?
                                $clog2(NUM_FILTERS) : 1
) (
    input  logic                        i_sys_clk,
    input  logic                        i_reset,
    input  logic                        i_can_ready,
    input  logic [MSG_W-1:0]            i_rx_message,
    input  logic [NUM_FILTERS*ID_W-1:0] i_afmr,
    input  logic [NUM_FILTERS*ID_W-1:0] i_afir,
    input  logic [NUM_FILTERS-1:0]      i_uaf,
    input  logic                        i_rx_full,
    output logic                        o_rx_w_en,
    output logic [MSG_W-1:0]            o_rx_fifo_w_data,
    output logic                        o_acfbsy,
    output logic [IDX_W-1:0]            o_af_hit_idx,
    output logic [CNT_W-1:0]            o_reject_cnt,
    output logic [CNT_W-1:0]            o_overrun_cnt
);

    af_state_t        r_state;
    af_state_t        w_next;
    logic [MSG_W-1:0] r_data;
    logic [IDX_W-1:0] r_hit_idx;
    logic             w_accept;
    logic [IDX_W-1:0] w_hit_idx;

    can_af_match_unit #(
        .NUM_FILTERS (NUM_FILTERS),
        .ID_W        (ID_W),
        .IDX_W       (IDX_W)
    ) u_match (
        .i_id      (r_data[MSG_W-1 -: ID_W]),
        .i_afmr    (i_afmr),
        .i_afir    (i_afir),
        .i_uaf     (i_uaf),
        .o_accept  (w_accept),
        .o_hit_idx (w_hit_idx)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (i_can_ready) w_next = S_EVAL;
            end
            S_EVAL: begin
                if (!w_accept)     w_next = S_IDLE;
                else if (i_rx_full) w_next = S_WAIT_FIFO;
                else               w_next = S_WRITE;
            end
            S_WAIT_FIFO: begin
                if (!i_rx_full) w_next = S_WRITE;
            end
            S_WRITE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_state   <= S_IDLE;
            r_data    <= '0;
            r_hit_idx <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_can_ready) begin
                r_data <= i_rx_message;
            end
            if (r_state == S_EVAL && w_accept) begin
                r_hit_idx <= w_hit_idx;
            end
        end
    end

    assign o_rx_w_en        = (r_state == S_WRITE);
    assign o_acfbsy         = (r_state != S_IDLE);
    assign o_rx_fifo_w_data = r_data;
    assign o_af_hit_idx     = r_hit_idx;

`ifdef CAN_AF_STATS_EN
    logic             w_reject;
    logic             w_overrun;
    logic [CNT_W-1:0] r_reject_cnt;
    logic [CNT_W-1:0] r_overrun_cnt;

    assign w_reject  = (r_state == S_EVAL) && !w_accept;
    assign w_overrun = (r_state != S_IDLE) && i_can_ready;

    // Both counters stick at all-ones rather than wrap.
    always_ff @(posedge i_sys_clk) begin
        if (i_reset) begin
            r_reject_cnt  <= '0;
            r_overrun_cnt <= '0;
        end else begin
            if (w_reject && !(&r_reject_cnt)) begin
                r_reject_cnt <= r_reject_cnt + CNT_W'(1);
            end
            if (w_overrun && !(&r_overrun_cnt)) begin
                r_overrun_cnt <= r_overrun_cnt + CNT_W'(1);
            end
        end
    end

    assign o_reject_cnt  = r_reject_cnt;
    assign o_overrun_cnt = r_overrun_cnt;
`else
    assign o_reject_cnt  = '0;
    assign o_overrun_cnt = '0;
`endif

endmodule
